sram_responder: RTL

- Word-organised SRAM model: the responder side of the datapath memory handshake (addr, read_en, write_en, data_in, data_out, mem_ready).
- Accepts one read or write request at a time, holds it for a programmable access latency, then completes it with a one-cycle mem_ready pulse.
- Serves both instruction fetch (PC-driven byte address, stepping by 4) and load/store traffic.
- Replaces the ad-hoc memory model as the instruction/data store for the milestone CPU.

---
 rtl/sram_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// Word-organised SRAM responder with a programmable access latency.
// Ports: clk, rst_n, addr, read_en, write_en, data_in -> data_out, mem_ready, mem_err, busy.
module sram_responder #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 7,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              read_en,
   input  logic              write_en,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              mem_ready,
   output logic              mem_err,
   output logic              busy
);

   localparam int IDX_W = ADDR_W - 2;
   localparam int DEPTH = 2 ** IDX_W;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] data_q;
   logic              wr_q;
   logic              inv_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic req;
   logic bad;

   assign req = read_en | write_en;
   // Conflicting enables or a non-word-aligned address reject the request.
   assign bad = (read_en & write_en) | (addr[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx_q     <= '0;
         data_q    <= '0;
         wr_q      <= 1'b0;
         inv_q     <= 1'b0;
         data_out  <= '0;
         mem_ready <= 1'b0;
         mem_err   <= 1'b0;
         busy      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (req) begin
                  idx_q  <= addr[ADDR_W-1:2];
                  data_q <= data_in;
                  wr_q   <= write_en;
                  inv_q  <= bad;
                  cnt    <= CNT_INIT;
                  busy   <= 1'b1;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // Array access happens on the edge entering DONE,
                  // so data_out is stable for the whole ready pulse.
                  if (!inv_q) begin
                     if (wr_q) begin
                        mem[idx_q] <= data_q;
                     end else begin
                        data_out <= mem[idx_q];
                     end
                  end
                  mem_ready <= 1'b1;
                  mem_err   <= inv_q;
                  state     <= DONE;
               end
            end
            DONE: begin
               mem_ready <= 1'b0;
               mem_err   <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               mem_ready <= 1'b0;
               mem_err   <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
